// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
// Shares one combinational 64-entry register-file read mux between NUM_REQ
// requesters. A requester is accepted in IDLE, its address drives the mux
// select lines for one cycle (READ), and the captured word is returned on a
// one-hot valid/ready response channel (RESP).
// Optional build macro: RF_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin.
module regfile_read_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_ENTRIES  = 64,
  parameter int SELECT_WIDTH = $clog2(NUM_ENTRIES)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  input  logic [NUM_REQ-1:0][SELECT_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  output logic [SELECT_WIDTH-1:0]              mux_selects_o,
  input  logic [DATA_WIDTH-1:0]                mux_data_i,
  output logic [NUM_REQ-1:0]                   rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                rsp_data_o,
  input  logic [NUM_REQ-1:0]                   rsp_ready_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [IDX_W-1:0]        grant_reg;
  logic [SELECT_WIDTH-1:0] mux_selects_reg;
  logic [NUM_REQ-1:0]      rsp_valid_reg;
  logic [DATA_WIDTH-1:0]   rsp_data_reg;

  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0]      rot_valid;
  logic [NUM_REQ-1:0]      grant_onehot;
  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic                    accept;

  genvar gi;

  // Rotate the request vector so that position 0 is the requester at rr_ptr;
  // rot_idx[gi] is the real requester index seen at rotated position gi.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [IDX_W:0] sum;
      assign sum          = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
      assign rot_idx[gi]  = (sum >= (IDX_W+1)'(NUM_REQ))
                            ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                            : sum[IDX_W-1:0];
      assign rot_valid[gi] = req_valid_i[rot_idx[gi]];
    end
  endgenerate

  // First valid requester at or after rr_ptr (lowest rotated position wins).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) begin
        pick_found = 1'b1;
        pick_idx   = rot_idx[i];
      end
    end
  end

  // A request is taken only from IDLE; reset suppresses any accept.
  assign accept = (state_reg == ST_IDLE) && pick_found && !reset_i;

  // One-hot decodes for the accept strobe and the latched grant.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign req_ready_o[gi]  = accept && (pick_idx == IDX_W'(gi));
      assign grant_onehot[gi] = (grant_reg == IDX_W'(gi));
    end
  endgenerate

`ifdef RF_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at requester 0.
  assign rr_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] rr_ptr_next;

  // Next search base is the requester just after the one being granted.
  always_comb begin
    rr_ptr_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
  end

  // Round-robin pointer advances only when a grant is actually issued.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_reg <= '0;
    end else if (accept) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign rr_ptr = rr_ptr_reg;
`endif

  // Transaction sequencer: IDLE -> READ -> RESP -> IDLE, all outputs registered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= '0;
      mux_selects_reg <= '0;
      rsp_valid_reg   <= '0;
      rsp_data_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_found) begin
            grant_reg       <= pick_idx;
            mux_selects_reg <= req_addr_i[pick_idx];
            state_reg       <= ST_READ;
          end
        end
        ST_READ: begin
          rsp_data_reg  <= mux_data_i;
          rsp_valid_reg <= grant_onehot;
          state_reg     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i[grant_reg]) begin
            rsp_valid_reg <= '0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign mux_selects_o = mux_selects_reg;
  assign rsp_valid_o   = rsp_valid_reg;
  assign rsp_data_o    = rsp_data_reg;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter
// Directed scenarios followed by randomized traffic, checked cycle by cycle
// against a transaction-level reference model (timestamps per in-flight read).
module tb_regfile_read_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int NE = 64;
  localparam int SW = 6;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [N-1:0]      req_valid;
  logic [N-1:0][SW-1:0] req_addr;
  logic [N-1:0]      req_ready;
  logic [SW-1:0]     mux_selects;
  logic [DW-1:0]     mux_data;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [N-1:0]      rsp_ready;

  logic [DW-1:0]     mem [NE];

  always #5 clk = ~clk;

  // Behavioural register-file read mux (purely combinational).
  assign mux_data = mem[mux_selects];

  regfile_read_arbiter #(
    .NUM_REQ     (N),
    .DATA_WIDTH  (DW),
    .NUM_ENTRIES (NE),
    .SELECT_WIDTH(SW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid),
    .req_addr_i   (req_addr),
    .req_ready_o  (req_ready),
    .mux_selects_o(mux_selects),
    .mux_data_i   (mux_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .rsp_ready_i  (rsp_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: one read in flight, described by its age in cycles.
  bit            m_busy;
  int            m_age;
  int            m_k;
  int            m_ptr;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] m_data;

  // Last observed DUT outputs, for directed constant checks.
  logic [N-1:0]  obs_ready;
  logic [SW-1:0] obs_sel;
  logic [N-1:0]  obs_valid;
  logic [DW-1:0] obs_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int winner(input logic [N-1:0] v, input int ptr);
    int best;
    int bestd;
    best  = -1;
    bestd = N;
    for (int k = 0; k < N; k++) begin
      if (v[k]) begin
        int d;
        d = (k - ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_age  = 0;
    m_k    = 0;
    m_ptr  = 0;
    m_sel  = '0;
    m_data = '0;
  endtask

  // One clock cycle: predict, sample mid-cycle, step the model at the edge.
  // Called just after a falling edge with inputs already applied.
  task automatic do_cycle();
    logic [N-1:0] e_ready;
    logic [N-1:0] e_valid;
    int           w;
    e_ready = '0;
    e_valid = '0;
    w       = -1;
    if (!reset_i && !m_busy) begin
      w = winner(req_valid, m_ptr);
      if (w >= 0) e_ready[w] = 1'b1;
    end
    if (m_busy && m_age >= 2) e_valid[m_k] = 1'b1;
    #1;
    obs_ready = req_ready;
    obs_sel   = mux_selects;
    obs_valid = rsp_valid;
    obs_data  = rsp_data;
    check("req_ready", 64'(obs_ready), 64'(e_ready));
    check("mux_sel",   64'(obs_sel),   64'(m_sel));
    check("rsp_valid", 64'(obs_valid), 64'(e_valid));
    check("rsp_data",  obs_data,       m_data);
    @(posedge clk);
    if (reset_i) begin
      model_reset();
      w = -1;
    end else if (w >= 0) begin
      m_busy = 1'b1;
      m_age  = 1;
      m_k    = w;
      m_sel  = req_addr[w];
`ifdef RF_ARB_FIXED_PRIO_EN
      m_ptr  = 0;
`else
      m_ptr  = (w + 1) % N;
`endif
    end else if (m_busy) begin
      if (m_age >= 2) begin
        if (rsp_ready[m_k]) begin
          m_busy = 1'b0;
          $display("txn req=%0d addr=%0d data=%h done_cycle=%0d", m_k, m_sel, m_data, cyc);
        end
      end else begin
        m_data = mem[m_sel];
        m_age  = 2;
      end
    end
    cyc++;
    @(negedge clk);
    if (w >= 0) req_valid[w] = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic single_read(input int k, input logic [SW-1:0] addr, input string tag);
    logic [N-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    req_valid[k] = 1'b1;
    req_addr[k]  = addr;
    do_cycle();
    check({tag, "_ready"}, 64'(obs_ready), 64'(oh));
    do_cycle();
    check({tag, "_sel"}, 64'(obs_sel), 64'(addr));
    do_cycle();
    check({tag, "_valid"}, 64'(obs_valid), 64'(oh));
    check({tag, "_data"}, obs_data, mem[addr]);
    do_cycle();
  endtask

  int grants[$];
  int rsp_cycles[$];

  initial begin
    for (int i = 0; i < NE; i++) mem[i] = {16'hA5C3, 10'(i), 6'(i), $urandom};
    mem[37] = 64'hDEAD_BEEF_0000_0025;
    mem[0]  = 64'h0123_4567_89AB_CDEF;
    mem[63] = 64'hFEDC_BA98_7654_3210;

    reset_i   = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = '1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    do_cycle();
    check("rst_valid", 64'(obs_valid), 64'(0));
    check("rst_sel",   64'(obs_sel),   64'(0));
    check("rst_data",  obs_data,       64'(0));
    reset_i = 1'b0;

    // Single request from requester 2 at address 37.
    single_read(2, 6'd37, "t1");
    check("t1_word", obs_data, 64'hDEAD_BEEF_0000_0025);

    // Fresh reset, then all requesters held valid continuously.
    reset_i = 1'b1;
    do_cycle();
    reset_i = 1'b0;
    for (int k = 0; k < N; k++) req_addr[k] = SW'(k * 10 + 5);
    for (int i = 0; i < 16; i++) begin
      req_valid = '1;
      do_cycle();
      for (int k = 0; k < N; k++) if (obs_ready[k]) grants.push_back(k);
      if (obs_valid != '0) rsp_cycles.push_back(cyc - 1);
    end
    check("rr_count", 64'(grants.size()), 64'(6));
    for (int i = 0; i < 5 && i < grants.size(); i++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      check("fp_order", 64'(grants[i]), 64'(0));
`else
      check("rr_order", 64'(grants[i]), 64'(i % N));
`endif
    end
    for (int i = 1; i < rsp_cycles.size(); i++)
      check("rsp_spacing", 64'(rsp_cycles[i] - rsp_cycles[i-1]), 64'(3));
    req_valid = '0;
    run_cycles(4);

    // Backpressure on requester 1 while requester 0 waits.
    rsp_ready = 4'b1101;
    req_valid = 4'b0010;
    req_addr[1] = 6'd12;
    do_cycle();
    req_valid[0] = 1'b1;
    req_addr[0]  = 6'd5;
    do_cycle();
    for (int i = 0; i < 10; i++) begin
      do_cycle();
      check("bp_valid", 64'(obs_valid), 64'(4'b0010));
      check("bp_data",  obs_data,       mem[12]);
      check("bp_ready", 64'(obs_ready), 64'(0));
    end
    rsp_ready = '1;
    do_cycle();
    do_cycle();
    check("bp_done_valid", 64'(obs_valid), 64'(0));
    check("bp_next_grant", 64'(obs_ready), 64'(4'b0001));
    run_cycles(3);

    // Ready from a non-granted requester must not complete the response.
    rsp_ready = 4'b1000;
    req_valid = 4'b0010;
    req_addr[1] = 6'd20;
    run_cycles(2);
    for (int i = 0; i < 4; i++) begin
      do_cycle();
      check("wr_hold", 64'(obs_valid), 64'(4'b0010));
    end
    rsp_ready = '1;
    run_cycles(2);
    check("wr_done", 64'(obs_valid), 64'(0));

    // Address boundaries.
    single_read(3, 6'd0, "lo");
    single_read(0, 6'd63, "hi");

    // Reset while the read is in flight.
    req_valid = 4'b0100;
    req_addr[2] = 6'd9;
    do_cycle();
    reset_i = 1'b1;
    do_cycle();
    reset_i = 1'b0;
    do_cycle();
    check("mr_valid", 64'(obs_valid), 64'(0));
    check("mr_sel",   64'(obs_sel),   64'(0));
    check("mr_data",  obs_data,       64'(0));
    req_valid = 4'b1001;
    req_addr[0] = 6'd44;
    req_addr[3] = 6'd45;
    do_cycle();
    check("mr_grant0", 64'(obs_ready), 64'(4'b0001));
    run_cycles(8);

    // Randomized traffic with random response backpressure.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
          req_valid[k] = 1'b1;
          req_addr[k]  = SW'($urandom_range(0, NE - 1));
        end
        rsp_ready[k] = ($urandom_range(0, 3) != 0);
      end
      do_cycle();
    end
    req_valid = '0;
    rsp_ready = '1;
    run_cycles(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
